// File: rtl/sar_search_if.sv
// Handshake and comparator bus between a successive-approximation search engine
// and its requester/comparator side.
interface sar_search_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             cmp_lt;
  logic             cmp_eq;
  logic             cmp_gt;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             error;

  modport master (
    output start, cmp_lt, cmp_eq, cmp_gt,
    input  guess, busy, done, result, found, error
  );

  modport slave (
    input  start, cmp_lt, cmp_eq, cmp_gt,
    output guess, busy, done, result, found, error
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search: drives trial values to an external combinational
// comparator and narrows in on the target one bit per cycle, stopping early on equality.
module sar_search #(
  parameter int unsigned WIDTH = 8
) (
  input logic         clk,
  input logic         reset,
  sar_search_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRIAL = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MaskTop = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           stateQ, stateD;
  logic [WIDTH-1:0] maskQ, maskD;
  logic [WIDTH-1:0] resultQ, resultD;
  logic             foundQ, foundD;
  logic             errorQ, errorD;

  logic [WIDTH-1:0] trialGuess;
  logic [WIDTH-1:0] guessC;
  logic             busyC;
  logic             doneC;
  logic [2:0]       flags;

  // Result bits and the trial bit never overlap, so OR forms the next candidate.
  assign trialGuess = resultQ | maskQ;
  assign flags      = {bus.cmp_lt, bus.cmp_eq, bus.cmp_gt};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ  <= IDLE;
      maskQ   <= '0;
      resultQ <= '0;
      foundQ  <= 1'b0;
      errorQ  <= 1'b0;
    end else begin
      stateQ  <= stateD;
      maskQ   <= maskD;
      resultQ <= resultD;
      foundQ  <= foundD;
      errorQ  <= errorD;
    end
  end

  always_comb begin
    stateD  = stateQ;
    maskD   = maskQ;
    resultD = resultQ;
    foundD  = foundQ;
    errorD  = errorQ;
    guessC  = resultQ;
    busyC   = 1'b0;
    doneC   = 1'b0;

    case (stateQ)
      IDLE: begin
        if (bus.start) begin
          resultD = '0;
          maskD   = MaskTop;
          foundD  = 1'b0;
          errorD  = 1'b0;
          stateD  = TRIAL;
        end
      end

      TRIAL: begin
        busyC  = 1'b1;
        guessC = trialGuess;
        // Anything other than exactly one flag means the comparator cannot be trusted.
        case (flags)
          3'b010: begin
            resultD = trialGuess;
            foundD  = 1'b1;
            stateD  = DONE;
          end
          3'b100, 3'b001: begin
            if (flags[2]) begin
              resultD = trialGuess;
            end
            if (maskQ[0]) begin
              stateD = DONE;
            end else begin
              maskD = maskQ >> 1;
            end
          end
          default: begin
            errorD = 1'b1;
            stateD = DONE;
          end
        endcase
      end

      DONE: begin
        doneC  = 1'b1;
        stateD = IDLE;
      end

      default: begin
        stateD = IDLE;
      end
    endcase
  end

  assign bus.guess  = guessC;
  assign bus.busy   = busyC;
  assign bus.done   = doneC;
  assign bus.result = resultQ;
  assign bus.found  = foundQ;
  assign bus.error  = errorQ;

endmodule

// File: doc/sar_search.md
# sar_search

Sequential successive-approximation search engine that finds an unknown unsigned value B by driving trial values onto the A input of an external magnitude comparator and consuming its three result flags. It closes the loop around the combinational comparator in the FSM-D datapath: the comparator answers "how does A relate to B", and this block decides the next A. It converges in at most WIDTH trials, stopping early on equality, and flags inconsistent comparator answers.

## Interface
- WIDTH, 8, bit width of guess/result and of the comparator operands
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a new search; sampled only in IDLE
- cmp_lt  input  1  comparator: guess < target
- cmp_eq  input  1  comparator: guess == target
- cmp_gt  input  1  comparator: guess > target
- guess  output  WIDTH  trial value driven to comparator A
- busy  output  1  high while in TRIAL
- done  output  1  one-cycle pulse when a search ends
- result  output  WIDTH  final search value, held until next start
- found  output  1  equality was observed during the last search
- error  output  1  last search aborted on a non-one-hot flag set

## Operation
- States: IDLE, TRIAL, DONE. Registers: state, mask_q (one-hot trial bit), result_q, found_q, error_q.
- IDLE: guess = result_q. On start=1: result_q←0, mask_q←1<<(WIDTH-1), found_q←0, error_q←0, go TRIAL.
- TRIAL: guess = result_q | mask_q (combinational). Flags are sampled in the same cycle (comparator is combinational):
  - flags not exactly one-hot (none or more than one set): error_q←1, result_q unchanged, go DONE.
  - cmp_eq: result_q←guess, found_q←1, go DONE.
  - cmp_lt: result_q←guess (keep bit); cmp_gt: result_q unchanged (drop bit).
  - lt/gt with mask_q[0]=1: go DONE; else mask_q←mask_q>>1, stay TRIAL.
- DONE: done=1 for exactly one cycle; guess = result_q; go IDLE unconditionally.
- start ignored in TRIAL and DONE (no queuing).
- Search without equality (only target 0 with a consistent comparator): result=0, found=0, error=0.
- result, found, error hold their values from DONE until the next accepted start.
- busy = (state==TRIAL). All arithmetic is unsigned, WIDTH bits, with no carries. The OR of result_q and mask_q never overflows.

## Timing
- Reset (asynchronous, any state, including mid-search): state=IDLE, mask_q=0, result_q=0, found=0, error=0, busy=0, done=0, guess=0.
- start sampled at edge 0 → TRIAL in cycles 1..k. k ≤ WIDTH is the trial that ends the search. done=1 in cycle k+1, and the block is back in IDLE in cycle k+2.
- Worst-case latency from start to done is WIDTH+1 cycles. Minimum is 2 cycles (eq on the first trial).
- result, found and error are valid in the done cycle and remain stable afterwards.
- A start held high continuously restarts a search in the cycle after DONE, on entry to IDLE.
- Flags must settle within the same cycle guess changes. No flag registering occurs in this block.

## Test plan
- WIDTH=8, target 0x5A: guesses 0x80,0x40,0x60,0x50,0x58,0x5C,0x5A in cycles 1–7 → done in cycle 8, result=0x5A, found=1, error=0.
- Target 0xFF: guesses 0x80,0xC0,…,0xFE,0xFF, all lt until eq on the 8th → done in cycle 9, result=0xFF, found=1.
- Target 0x00: eight gt answers → done in cycle 9, result=0x00, found=0, error=0. Target 0x80: eq on trial 1 → done in cycle 2.
- Fault injection: force cmp_lt=cmp_gt=1 on trial 3 of target 0x5A → done the next cycle, error=1, found=0, result=0x40. Also check the all-zero flag case, which must likewise set error.
- Assert reset during trial 4, then release → all outputs 0 and state IDLE. A start pulse in mid-TRIAL is ignored (the guess sequence is unchanged). A new start after done clears found/error and searches correctly.
- Random regression with WIDTH=4 and WIDTH=12 against a behavioural comparator model, all targets → result==target (found=1, except target 0) and done within WIDTH+1 cycles.
